sqrt_sched: RTL and testbench

Round-robin scheduler that shares one iterative square-root engine between `NREQ` requesters in the image-matching datapath. It arbitrates requests, latches the winning radical, and sequences a restoring bit-pair square root at one result bit per clock. It returns quotient, remainder and requester ID over a valid/ready output handshake. It replaces per-requester instances of the pipelined sqrt, trading throughput for area.

---
 rtl/sqrt_sched_if.sv | 29 ++
 rtl/sqrt_sched.sv | 115 +++++++++++
 tb/tb_sqrt_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sqrt_sched_if.sv
// rtl/sqrt_sched_if.sv - request/grant and result handshake bundle for sqrt_sched
interface sqrt_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) ();
  localparam int QW = (WIDTH + 1) / 2;
  localparam int RW = QW + 1;
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] radical;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [QW-1:0]         q;
  logic [RW-1:0]         remainder;
  logic [IW-1:0]         out_id;

  modport slave (
    input  req, radical, out_ready,
    output gnt, busy, out_valid, q, remainder, out_id
  );

  modport master (
    output req, radical, out_ready,
    input  gnt, busy, out_valid, q, remainder, out_id
  );
endinterface

// File: rtl/sqrt_sched.sv
// rtl/sqrt_sched.sv - round-robin scheduler sharing one bit-pair restoring sqrt engine
// Define SQRT_SCHED_ZERO_SKIP_EN to send zero radicals straight from grant to OUT.
module sqrt_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         aclr,
  sqrt_sched_if.slave bus
);
  localparam int QW = (WIDTH + 1) / 2;
  localparam int RW = QW + 1;
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   last_id, out_id_r, win;
  logic            found;
  logic [2*QW-1:0] rad;
  logic [RW-1:0]   r;
  logic [QW-1:0]   qr;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] rad_sel;
  logic            zero_skip;
  logic [1:0]      pair;
  logic [RW:0]     r_sh, t, r_diff;
  logic            ge;
  logic [QW-1:0]   q_next;
  logic [RW-1:0]   r_next;

  // Search upward from the previous winner so a persistent requester yields to the others.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_id) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign rad_sel = bus.radical[int'(win)*WIDTH +: WIDTH];

`ifdef SQRT_SCHED_ZERO_SKIP_EN
  assign zero_skip = (rad_sel == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // One restoring step; RW+1 bits hold the shifted partial remainder without overflow.
  assign pair   = rad[2*QW-1 -: 2];
  assign r_sh   = (RW+1)'({r, pair});
  assign t      = (RW+1)'({qr, 2'b01});
  assign ge     = (r_sh >= t);
  assign r_diff = r_sh - t;
  assign r_next = ge ? RW'(r_diff) : RW'(r_sh);
  assign q_next = QW'({qr, ge});

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = zero_skip ? OUT : CALC;
      CALC:    if (cnt == '0) state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= IDLE;
      last_id  <= IW'(NREQ - 1);
      out_id_r <= '0;
      rad      <= '0;
      r        <= '0;
      qr       <= '0;
      cnt      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (found) begin
            rad      <= (2*QW)'(rad_sel);
            last_id  <= win;
            out_id_r <= win;
            r        <= '0;
            qr       <= '0;
            cnt      <= CW'(QW - 1);
          end
        end
        CALC: begin
          rad <= rad << 2;
          r   <= r_next;
          qr  <= q_next;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = (state == IDLE && found) ? (NREQ'(1) << win) : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.q         = qr;
  assign bus.remainder = r;
  assign bus.out_id    = out_id_r;
endmodule

// File: tb/tb_sqrt_sched.sv
// tb/tb_sqrt_sched.sv - directed checks of sqrt_sched at WIDTH=16/NREQ=4 and WIDTH=9/NREQ=2
module tb_sqrt_sched;
  logic clk = 1'b0;
  logic aclr;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_sched_if #(.NREQ(4), .WIDTH(16)) b16 ();
  sqrt_sched_if #(.NREQ(2), .WIDTH(9))  b9 ();

  sqrt_sched #(.NREQ(4), .WIDTH(16)) dut16 (.clk(clk), .aclr(aclr), .bus(b16));
  sqrt_sched #(.NREQ(2), .WIDTH(9))  dut9  (.clk(clk), .aclr(aclr), .bus(b9));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // n counts clock edges after the grant edge until out_valid is seen.
  task automatic run16(input int id, input logic [15:0] rv, input int eq, input int er, input int lat);
    int n;
    @(negedge clk);
    b16.req[id] = 1'b1;
    b16.radical[id*16 +: 16] = rv;
    #1 check("gnt16", b16.gnt, 32'(1 << id));
    @(negedge clk);
    b16.req[id] = 1'b0;
    b16.radical = '1;
    n = 0;
    while (!b16.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("lat16", n, lat);
    check("q16", b16.q, eq);
    check("rem16", b16.remainder, er);
    check("id16", b16.out_id, id);
    b16.out_ready = 1'b1;
    @(negedge clk);
    b16.out_ready = 1'b0;
    check("rel16", b16.out_valid, 0);
  endtask

  task automatic run9(input int id, input logic [8:0] rv, input int eq, input int er, input int lat);
    int n;
    @(negedge clk);
    b9.req[id] = 1'b1;
    b9.radical[id*9 +: 9] = rv;
    #1 check("gnt9", b9.gnt, 32'(1 << id));
    @(negedge clk);
    b9.req[id] = 1'b0;
    n = 0;
    while (!b9.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("lat9", n, lat);
    check("q9", b9.q, eq);
    check("rem9", b9.remainder, er);
    check("id9", b9.out_id, id);
    b9.out_ready = 1'b1;
    @(negedge clk);
    b9.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int ng;
    int ids[5];
    int cycs[5];
    int zlat;

    aclr = 1'b1;
    b16.req = '0; b16.radical = '0; b16.out_ready = 1'b0;
    b9.req = '0;  b9.radical = '0;  b9.out_ready = 1'b0;
    #1;
    check("rst_outs", {b16.busy, b16.out_valid, b16.q, b16.remainder, b16.out_id}, 0);
    check("rst_gnt0", b16.gnt, 0);
    b16.req = 4'b0100;
    #1 check("rst_gnt_live", b16.gnt, 4'b0100);
    b16.req = '0;
    @(negedge clk);
    aclr = 1'b0;

    run16(0, 16'd100, 10, 0, 8);
    run16(2, 16'hFFFF, 255, 510, 8);

    // Result held under back-pressure while another request waits.
    @(negedge clk);
    b16.req[1] = 1'b1;
    b16.radical[16 +: 16] = 16'd50;
    @(negedge clk);
    b16.req[1] = 1'b0;
    n = 0;
    while (!b16.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    b16.req[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("hold", {b16.out_valid, b16.q, b16.remainder, b16.out_id, b16.gnt},
                {1'b1, 8'd7, 9'd1, 2'd1, 4'd0});
    end
    b16.out_ready = 1'b1;
    @(negedge clk);
    b16.out_ready = 1'b0;
    #1 check("next_gnt", b16.gnt, 4'b1000);
    b16.req[3] = 1'b0;
    #1 check("withdraw", b16.gnt, 0);
    @(negedge clk);
    check("no_grant", b16.busy, 0);

    // Reset in the middle of CALC.
    @(negedge clk);
    b16.req[0] = 1'b1;
    b16.radical[0 +: 16] = 16'd144;
    @(negedge clk);
    b16.req[0] = 1'b0;
    repeat (3) @(negedge clk);
    aclr = 1'b1;
    #1 check("aclr_outs", {b16.busy, b16.out_valid, b16.q, b16.remainder, b16.out_id}, 0);
    @(negedge clk);
    aclr = 1'b0;
    repeat (3) @(negedge clk);
    check("aclr_no_result", b16.out_valid, 0);
    run16(3, 16'd144, 12, 0, 8);

    // Continuous requests from everyone: rotation order and spacing.
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    b16.radical = {16'd36, 16'd25, 16'd16, 16'd9};
    b16.out_ready = 1'b1;
    b16.req = 4'b1111;
    ng = 0;
    for (int k = 0; k < 120 && ng < 5; k++) begin
      #1;
      if (b16.gnt != '0) begin
        ids[ng] = 0;
        for (int b = 0; b < 4; b++) if (b16.gnt[b]) ids[ng] = b;
        cycs[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    b16.req = '0;
    check("rr_count", ng, 5);
    check("rr_order", {ids[0][3:0], ids[1][3:0], ids[2][3:0], ids[3][3:0], ids[4][3:0]},
          20'h01230);
    for (int i = 1; i < 5; i++) check("rr_gap", cycs[i] - cycs[i-1], 10);
    repeat (20) @(negedge clk);
    b16.out_ready = 1'b0;
    check("rr_drained", b16.busy, 0);

    run9(1, 9'd511, 22, 27, 5);
`ifdef SQRT_SCHED_ZERO_SKIP_EN
    zlat = 0;   // grant edge enters OUT directly
`else
    zlat = 5;
`endif
    run9(0, 9'd0, 0, 0, zlat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
